// File: rtl/waveform_stats.sv
// Per-window waveform measurement: hysteresis trigger, max/min/sum accumulation
// over 1/2/4/8 periods, and a restoring divider that produces the window mean.
module waveform_stats #(
    parameter int unsigned DW   = 12,
    parameter int unsigned CW   = 25,
    parameter int unsigned HYST = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    input  logic          i_din_valid,
    input  logic [DW-1:0] i_data_in,
    input  logic [DW-1:0] i_trig,
    input  logic [1:0]    i_avg_sel,
    output logic [CW-1:0] o_period,
    output logic [DW-1:0] o_max_v,
    output logic [DW-1:0] o_min_v,
    output logic [DW-1:0] o_vpp,
    output logic [DW-1:0] o_mean_v,
    output logic          o_res_valid,
    output logic          o_busy,
    output logic          o_timeout,
    output logic          o_overrun
);

    localparam int unsigned SW  = DW + CW;
    localparam int unsigned DCW = $clog2(SW + 1);
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic {S_IDLE, S_ACCUM} state_t;
    typedef enum logic {D_IDLE, D_RUN}   dstate_t;

    state_t          r_state, w_state_nx;
    dstate_t         r_dstate, w_dstate_nx;

    logic            r_armed;
    logic [CW-1:0]   r_cnt;
    logic [DW-1:0]   r_max, r_min;
    logic [SW-1:0]   r_sum;
    logic [3:0]      r_periods, r_n;

    logic [CW-1:0]   r_s_cnt;
    logic [DW-1:0]   r_s_max, r_s_min;
    logic [SW-1:0]   r_q;
    logic [CW-1:0]   r_rem;
    logic [DCW-1:0]  r_div_cnt;

    logic [CW-1:0]   r_period;
    logic [DW-1:0]   r_max_v, r_min_v, r_vpp, r_mean_v;
    logic            r_res_valid, r_timeout, r_overrun;

    // Arming threshold TRIG-HYST, clamped at zero when it underflows
    logic [DW:0]     w_thr_diff;
    logic [DW-1:0]   w_thr;
    logic            w_valid, w_arm, w_trig, w_start, w_close, w_timeout;
    logic            w_div_done, w_div_free, w_div_start, w_overrun, w_restart;
    logic [CW:0]     w_rem_sh;
    logic            w_ge;
    logic [CW-1:0]   w_rem_nx;

    assign w_thr_diff  = {1'b0, i_trig} - (DW+1)'(HYST);
    assign w_thr       = w_thr_diff[DW] ? '0 : w_thr_diff[DW-1:0];
    assign w_valid     = i_din_valid && i_en;
    assign w_arm       = w_valid && (i_data_in < w_thr);
    assign w_trig      = w_valid && r_armed && (i_data_in >= i_trig);
    assign w_start     = (r_state == S_IDLE) && w_trig;
    assign w_close     = (r_state == S_ACCUM) && w_trig && (r_periods == r_n);
    assign w_timeout   = (r_state == S_ACCUM) && w_valid && !w_close && (r_cnt == CNT_MAX);
    assign w_div_done  = i_en && (r_dstate == D_RUN) && (r_div_cnt == DCW'(SW));
    // A divide finishing on this edge frees the divider for a closing trigger on the same edge
    assign w_div_free  = (r_dstate == D_IDLE) || w_div_done;
    assign w_div_start = w_close && w_div_free;
    assign w_overrun   = w_close && !w_div_free;
    assign w_restart   = w_start || w_close;

    assign w_rem_sh    = {r_rem, r_q[SW-1]};
    assign w_ge        = (w_rem_sh >= {1'b0, r_s_cnt});
    assign w_rem_nx    = CW'(w_ge ? (w_rem_sh - {1'b0, r_s_cnt}) : w_rem_sh);

    // State registers for the window and divider FSMs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_dstate <= D_IDLE;
        end else begin
            r_state  <= w_state_nx;
            r_dstate <= w_dstate_nx;
        end
    end

    // Window FSM next state
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (w_start)   w_state_nx = S_ACCUM;
            S_ACCUM: if (w_timeout) w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
        if (!i_en) w_state_nx = S_IDLE;
    end

    // Divider FSM next state
    always_comb begin
        w_dstate_nx = r_dstate;
        case (r_dstate)
            D_IDLE:  if (w_div_start) w_dstate_nx = D_RUN;
            D_RUN:   if (w_div_done && !w_div_start) w_dstate_nx = D_IDLE;
            default: w_dstate_nx = D_IDLE;
        endcase
        if (!i_en) w_dstate_nx = D_IDLE;
    end

    // Trigger tracking, accumulators, divider datapath and result registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_armed     <= 1'b0;
            r_cnt       <= '0;
            r_max       <= '0;
            r_min       <= '0;
            r_sum       <= '0;
            r_periods   <= '0;
            r_n         <= '0;
            r_s_cnt     <= '0;
            r_s_max     <= '0;
            r_s_min     <= '0;
            r_q         <= '0;
            r_rem       <= '0;
            r_div_cnt   <= '0;
            r_period    <= '0;
            r_max_v     <= '0;
            r_min_v     <= '0;
            r_vpp       <= '0;
            r_mean_v    <= '0;
            r_res_valid <= 1'b0;
            r_timeout   <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_res_valid <= w_div_done;
            r_timeout   <= w_timeout;
            r_overrun   <= w_overrun;

            if (!i_en || w_timeout || w_trig) r_armed <= 1'b0;
            else if (w_arm)                   r_armed <= 1'b1;

            if (w_restart) begin
                r_cnt     <= CW'(1);
                r_max     <= i_data_in;
                r_min     <= i_data_in;
                r_sum     <= SW'(i_data_in);
                r_periods <= 4'd1;
                r_n       <= 4'(4'd1 << i_avg_sel);
            end else if ((r_state == S_ACCUM) && w_valid && !w_timeout) begin
                r_cnt <= r_cnt + CW'(1);
                r_sum <= r_sum + SW'(i_data_in);
                if (i_data_in > r_max) r_max <= i_data_in;
                if (i_data_in < r_min) r_min <= i_data_in;
                if (w_trig) r_periods <= r_periods + 4'd1;
            end

            if (w_div_start) begin
                r_s_cnt   <= r_cnt;
                r_s_max   <= r_max;
                r_s_min   <= r_min;
                r_q       <= r_sum;
                r_rem     <= '0;
                r_div_cnt <= '0;
            end else if ((r_dstate == D_RUN) && !w_div_done) begin
                r_q       <= {r_q[SW-2:0], w_ge};
                r_rem     <= w_rem_nx;
                r_div_cnt <= r_div_cnt + DCW'(1);
            end

            // Quotient always fits DW bits since the mean never exceeds the max
            if (w_div_done) begin
                r_period <= r_s_cnt;
                r_max_v  <= r_s_max;
                r_min_v  <= r_s_min;
                r_vpp    <= r_s_max - r_s_min;
                r_mean_v <= r_q[DW-1:0];
            end
        end
    end

    assign o_period    = r_period;
    assign o_max_v     = r_max_v;
    assign o_min_v     = r_min_v;
    assign o_vpp       = r_vpp;
    assign o_mean_v    = r_mean_v;
    assign o_res_valid = r_res_valid;
    assign o_busy      = (r_dstate == D_RUN);
    assign o_timeout   = r_timeout;
    assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_waveform_stats.sv
// Directed bench for waveform_stats: square-wave vector table plus hysteresis,
// timeout, AVG_SEL change, and reset/enable-abort sequences.
module tb_waveform_stats;

    localparam int unsigned DW   = 12;
    localparam int unsigned CW   = 16;
    localparam int unsigned HYST = 16;

    logic          clk = 1'b0;
    logic          rst, en, din_valid;
    logic [DW-1:0] data_in, trig;
    logic [1:0]    avg_sel;
    logic [CW-1:0] o_period;
    logic [DW-1:0] o_max_v, o_min_v, o_vpp, o_mean_v;
    logic          o_res_valid, o_busy, o_timeout, o_overrun;

    waveform_stats #(.DW(DW), .CW(CW), .HYST(HYST)) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_din_valid(din_valid),
        .i_data_in(data_in), .i_trig(trig), .i_avg_sel(avg_sel),
        .o_period(o_period), .o_max_v(o_max_v), .o_min_v(o_min_v),
        .o_vpp(o_vpp), .o_mean_v(o_mean_v), .o_res_valid(o_res_valid),
        .o_busy(o_busy), .o_timeout(o_timeout), .o_overrun(o_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int avg; int nlo; int nhi; int lo; int hi;
        int period; int maxv; int minv; int vpp; int mean; int interval; int ovr;
    } vec_t;

    vec_t vecs[7];

    int tests = 0, fails = 0;
    int tick_no = 0;
    int rv_count, ov_count, to_count, to_tick;
    int rv_tick[2];
    int c_period, c_max, c_min, c_vpp, c_mean, c2_period;
    int g_ph, g_nlo, g_nhi;
    logic [DW-1:0] g_lo, g_hi;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        rv_count = 0; ov_count = 0; to_count = 0; to_tick = 0;
        rv_tick[0] = 0; rv_tick[1] = 0;
    endtask

    // One negedge: observe outputs of the previous posedge
    task automatic tick();
        @(negedge clk);
        tick_no++;
        if (o_res_valid) begin
            if (rv_count < 2) rv_tick[rv_count] = tick_no;
            if (rv_count == 0) begin
                c_period = int'(o_period); c_max = int'(o_max_v); c_min = int'(o_min_v);
                c_vpp = int'(o_vpp); c_mean = int'(o_mean_v);
            end
            if (rv_count == 1) c2_period = int'(o_period);
            rv_count++;
        end
        if (o_overrun) ov_count++;
        if (o_timeout) begin
            to_count++;
            to_tick = tick_no;
        end
    endtask

    task automatic send(input logic v, input logic [DW-1:0] d);
        tick();
        din_valid = v;
        data_in   = d;
    endtask

    task automatic gen_tick();
        send(1'b1, (g_ph < g_nlo) ? g_lo : g_hi);
        g_ph = (g_ph + 1 >= g_nlo + g_nhi) ? 0 : g_ph + 1;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1; din_valid = 1'b0; en = 1'b1;
        tick();
        rst = 1'b0;
        clear_mon();
    endtask

    task automatic set_gen(input int nlo, input int nhi, input int lo, input int hi);
        g_nlo = nlo; g_nhi = nhi; g_lo = DW'(lo); g_hi = DW'(hi); g_ph = 0;
    endtask

    initial begin
        int t0, close_t, budget;
        vecs[0] = '{0, 10, 10,  100, 3000, 20, 3000,  100, 2900, 1550, 40, 1};
        vecs[1] = '{2, 10, 10,  100, 3000, 80, 3000,  100, 2900, 1550, 80, 0};
        vecs[2] = '{1, 15, 15,    0, 4095, 60, 4095,    0, 4095, 2047, 60, 0};
        vecs[3] = '{3,  3,  2, 1000, 2100, 40, 2100, 1000, 1100, 1440, 40, 0};
        vecs[4] = '{0, 20,  9, 2031, 2048, 29, 2048, 2031,   17, 2036, 29, 0};
        vecs[5] = '{0, 14, 14,  200, 3500, 28, 3500,  200, 3300, 1850, 56, 1};
        vecs[6] = '{0,  5,  5,  100, 3000, 10, 3000,  100, 2900, 1550, 30, 1};

        rst = 1'b1; en = 1'b1; din_valid = 1'b0; data_in = '0; trig = 12'd2048; avg_sel = 2'd0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_period", o_period, 0);
        check("rst_max", o_max_v, 0);
        check("rst_min", o_min_v, 0);
        check("rst_vpp", o_vpp, 0);
        check("rst_mean", o_mean_v, 0);
        check("rst_rv", o_res_valid, 0);
        check("rst_busy", o_busy, 0);
        check("rst_timeout", o_timeout, 0);
        check("rst_overrun", o_overrun, 0);

        // Square-wave vector table
        for (int i = 0; i < 7; i++) begin
            avg_sel = 2'(vecs[i].avg);
            do_reset();
            set_gen(vecs[i].nlo, vecs[i].nhi, vecs[i].lo, vecs[i].hi);
            t0 = tick_no;
            budget = 0;
            while (rv_count < 2 && budget < 1000) begin
                gen_tick();
                budget++;
            end
            check($sformatf("v%0d_rv_seen", i), rv_count >= 2, 1);
            close_t = t0 + vecs[i].nlo + 1 + (1 << vecs[i].avg) * (vecs[i].nlo + vecs[i].nhi);
            check($sformatf("v%0d_latency", i), rv_tick[0] - close_t - 1, 29);
            check($sformatf("v%0d_period", i), c_period, vecs[i].period);
            check($sformatf("v%0d_max", i), c_max, vecs[i].maxv);
            check($sformatf("v%0d_min", i), c_min, vecs[i].minv);
            check($sformatf("v%0d_vpp", i), c_vpp, vecs[i].vpp);
            check($sformatf("v%0d_mean", i), c_mean, vecs[i].mean);
            check($sformatf("v%0d_period2", i), c2_period, vecs[i].period);
            check($sformatf("v%0d_interval", i), rv_tick[1] - rv_tick[0], vecs[i].interval);
            check($sformatf("v%0d_overrun", i), ov_count > 0, vecs[i].ovr);
        end

        // Hysteresis: one trigger, no retrigger until a sample below 2032
        avg_sel = 2'd0;
        do_reset();
        send(1'b1, 12'd100);
        send(1'b1, 12'd2050);
        for (int k = 0; k < 9; k++) begin
            send(1'b1, 12'd2040);
            send(1'b1, 12'd2050);
        end
        send(1'b1, 12'd2040);
        send(1'b1, 12'd2031);
        send(1'b1, 12'd2050);
        close_t = tick_no;

        // Timeout: the window opened by that closing sample never closes
        budget = 0;
        while (to_count == 0 && budget < 70000) begin
            send(1'b1, 12'd500);
            budget++;
        end
        check("hyst_rv_count", rv_count, 1);
        check("hyst_period", c_period, 21);
        check("hyst_max", c_max, 2050);
        check("hyst_min", c_min, 2031);
        check("hyst_vpp", c_vpp, 19);
        check("hyst_mean", c_mean, 2044);
        check("hyst_latency", rv_tick[0] - close_t - 1, 29);
        check("to_seen", to_count, 1);
        check("to_samples", to_tick - close_t - 1, 65535);
        for (int k = 0; k < 40; k++) send(1'b1, 12'd500);
        check("to_rv_none", rv_count, 1);
        check("to_hold_period", o_period, 21);
        check("to_hold_mean", o_mean_v, 2044);
        check("to_hold_min", o_min_v, 2031);

        // Restart from IDLE after timeout, with ignored invalid samples inside
        clear_mon();
        send(1'b1, 12'd100);
        send(1'b1, 12'd3000);
        for (int k = 0; k < 14; k++) send(1'b1, 12'd100);
        for (int k = 0; k < 5; k++) send(1'b0, 12'd4095);
        send(1'b0, 12'd0);
        for (int k = 0; k < 15; k++) send(1'b1, 12'd100);
        send(1'b1, 12'd3000);
        close_t = tick_no;
        budget = 0;
        while (rv_count == 0 && budget < 60) begin
            send(1'b1, 12'd100);
            budget++;
        end
        check("post_to_rv", rv_count, 1);
        check("post_to_latency", rv_tick[0] - close_t - 1, 29);
        check("post_to_period", c_period, 30);
        check("post_to_max", c_max, 3000);
        check("post_to_min", c_min, 100);
        check("post_to_mean", c_mean, 196);

        // AVG_SEL change mid-window affects only the next window
        avg_sel = 2'd0;
        do_reset();
        set_gen(20, 20, 100, 3000);
        for (int k = 0; k < 25; k++) gen_tick();
        avg_sel = 2'd1;
        budget = 0;
        while (rv_count < 2 && budget < 400) begin
            gen_tick();
            budget++;
        end
        check("avgchg_period1", c_period, 40);
        check("avgchg_period2", c2_period, 80);
        check("avgchg_interval", rv_tick[1] - rv_tick[0], 80);
        check("avgchg_mean", c_mean, 1550);
        check("avgchg_overrun", ov_count, 0);

        // RST and EN=0 during a running divide
        for (int pass = 0; pass < 2; pass++) begin
            avg_sel = 2'd0;
            do_reset();
            set_gen(10, 10, 100, 3000);
            budget = 0;
            while (rv_count == 0 && budget < 200) begin
                gen_tick();
                budget++;
            end
            budget = 0;
            while (!o_busy && budget < 100) begin
                gen_tick();
                budget++;
            end
            check($sformatf("abort%0d_busy_seen", pass), o_busy, 1);
            for (int k = 0; k < 3; k++) gen_tick();
            tick();
            din_valid = 1'b1; data_in = 12'd100;
            if (pass == 0) rst = 1'b1; else en = 1'b0;
            tick();
            check($sformatf("abort%0d_busy_clr", pass), o_busy, 0);
            rst = 1'b0;
            tick();
            en = 1'b1;
            clear_mon();
            for (int k = 0; k < 60; k++) send(1'b1, 12'd100);
            check($sformatf("abort%0d_rv_none", pass), rv_count, 0);
            check($sformatf("abort%0d_busy", pass), o_busy, 0);
            check($sformatf("abort%0d_period", pass), o_period, pass == 0 ? 0 : 20);
            check($sformatf("abort%0d_max", pass), o_max_v, pass == 0 ? 0 : 3000);
            check($sformatf("abort%0d_min", pass), o_min_v, pass == 0 ? 0 : 100);
            check($sformatf("abort%0d_vpp", pass), o_vpp, pass == 0 ? 0 : 2900);
            check($sformatf("abort%0d_mean", pass), o_mean_v, pass == 0 ? 0 : 1550);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
